// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between the processor
//   writeback stage and two external requesters (e.g. board-IO and
//   motor-status logic posting values that software polls).
//
//   Processor writeback has priority and passes straight through with zero
//   latency. External writes use a 4-phase req/ack handshake. Each one is
//   captured into a per-port holding register and then drained in
//   round-robin order whenever the processor is not writing. A per-port
//   wait counter stalls the processor once a held write has been bypassed
//   MAX_WAIT times. Writes to register 0 never reach the regfile.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   proc_we      processor writeback enable
//   proc_wreg    processor destination register
//   proc_wdata   processor writeback data
//   proc_stall   registered; processor freezes writeback and holds proc_*
//   ext0_req     port 0 write request (4-phase)
//   ext0_reg     port 0 destination register
//   ext0_data    port 0 write data
//   ext0_ack     port 0 write completed (registered)
//   ext1_*       same as ext0_*, for port 1
//   rf_we        regfile write enable
//   rf_wreg      regfile write index
//   rf_wdata     regfile write data
module regfile_write_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned MAX_WAIT   = 8
) (
   input  logic                  clock,
   input  logic                  reset,

   input  logic                  proc_we,
   input  logic [ADDR_WIDTH-1:0] proc_wreg,
   input  logic [DATA_WIDTH-1:0] proc_wdata,
   output logic                  proc_stall,

   input  logic                  ext0_req,
   input  logic [ADDR_WIDTH-1:0] ext0_reg,
   input  logic [DATA_WIDTH-1:0] ext0_data,
   output logic                  ext0_ack,

   input  logic                  ext1_req,
   input  logic [ADDR_WIDTH-1:0] ext1_reg,
   input  logic [DATA_WIDTH-1:0] ext1_data,
   output logic                  ext1_ack,

   output logic                  rf_we,
   output logic [ADDR_WIDTH-1:0] rf_wreg,
   output logic [DATA_WIDTH-1:0] rf_wdata
);

   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

   typedef enum logic [1:0] {
      PORT_IDLE = 2'd0,
      PORT_HELD = 2'd1,
      PORT_DONE = 2'd2
   } port_state_t;

   // ------------------------------------------------------------------
   // Per-port views of the external interfaces
   // ------------------------------------------------------------------
   logic [1:0]            req;
   logic [ADDR_WIDTH-1:0] in_reg  [0:1];
   logic [DATA_WIDTH-1:0] in_data [0:1];

   assign req[0]     = ext0_req;
   assign req[1]     = ext1_req;
   assign in_reg[0]  = ext0_reg;
   assign in_reg[1]  = ext1_reg;
   assign in_data[0] = ext0_data;
   assign in_data[1] = ext1_data;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   port_state_t           state_q   [0:1];
   port_state_t           state_d   [0:1];
   logic [ADDR_WIDTH-1:0] hold_reg  [0:1];
   logic [DATA_WIDTH-1:0] hold_data [0:1];
   logic [7:0]            wait_q    [0:1];
   logic                  rr_q;
   logic                  stall_q;

   logic [1:0] held;
   logic [1:0] issue;
   logic [1:0] starve;
   logic       proc_issue;

   assign held[0] = (state_q[0] == PORT_HELD);
   assign held[1] = (state_q[1] == PORT_HELD);

   // ------------------------------------------------------------------
   // Issue selection: processor first, then held ports by round robin
   // ------------------------------------------------------------------
   always_comb begin
      issue      = '0;
      proc_issue = proc_we & ~stall_q;
      if (!proc_issue) begin
         if (held[0] && held[1]) begin
            if (rr_q) issue = 2'b10;
            else      issue = 2'b01;
         end else if (held[0]) begin
            issue = 2'b01;
         end else if (held[1]) begin
            issue = 2'b10;
         end
      end
   end

   // ------------------------------------------------------------------
   // Write-port mux
   // ------------------------------------------------------------------
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_reg;
   logic [DATA_WIDTH-1:0] wr_data;

   always_comb begin
      wr_en   = 1'b0;
      wr_reg  = '0;
      wr_data = '0;
      if (proc_issue) begin
         wr_en   = 1'b1;
         wr_reg  = proc_wreg;
         wr_data = proc_wdata;
      end else if (issue[0]) begin
         wr_en   = 1'b1;
         wr_reg  = hold_reg[0];
         wr_data = hold_data[0];
      end else if (issue[1]) begin
         wr_en   = 1'b1;
         wr_reg  = hold_reg[1];
         wr_data = hold_data[1];
      end
   end

   // Register 0 is hardwired: an issued write to it is consumed (and acked)
   // but never enables the regfile. Reset gates the enable combinationally
   // so a pass-through proc_we cannot leak out while reset is held.
   assign rf_we    = reset & wr_en & (wr_reg != '0);
   assign rf_wreg  = wr_reg;
   assign rf_wdata = wr_data;

   // ------------------------------------------------------------------
   // Per-port FSM next state
   // ------------------------------------------------------------------
   always_comb begin
      for (int unsigned k = 0; k < 2; k++) begin
         state_d[k[0]] = state_q[k[0]];
         case (state_q[k[0]])
            PORT_IDLE: if (req[k[0]])   state_d[k[0]] = PORT_HELD;
            PORT_HELD: if (issue[k[0]]) state_d[k[0]] = PORT_DONE;
            PORT_DONE: if (!req[k[0]])  state_d[k[0]] = PORT_IDLE;
            default:                    state_d[k[0]] = PORT_IDLE;
         endcase
      end
   end

   // A port starves this cycle if it has already been bypassed MAX_WAIT
   // times and is bypassed again; the stall then lands on the next edge.
   // The counter saturates, so the stall persists until that port issues.
   always_comb begin
      starve = '0;
      for (int unsigned k = 0; k < 2; k++) begin
         starve[k[0]] = held[k[0]] && !issue[k[0]] && (wait_q[k[0]] == WAIT_LIMIT);
      end
   end

   // ------------------------------------------------------------------
   // Sequential state
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned k = 0; k < 2; k++) begin
            state_q[k[0]]   <= PORT_IDLE;
            hold_reg[k[0]]  <= '0;
            hold_data[k[0]] <= '0;
            wait_q[k[0]]    <= '0;
         end
         rr_q    <= 1'b0;
         stall_q <= 1'b0;
      end else begin
         for (int unsigned k = 0; k < 2; k++) begin
            state_q[k[0]] <= state_d[k[0]];

            if (state_q[k[0]] == PORT_IDLE && req[k[0]]) begin
               hold_reg[k[0]]  <= in_reg[k[0]];
               hold_data[k[0]] <= in_data[k[0]];
            end

            if (held[k[0]] && !issue[k[0]]) begin
               if (wait_q[k[0]] < WAIT_LIMIT) wait_q[k[0]] <= wait_q[k[0]] + 8'd1;
            end else begin
               wait_q[k[0]] <= '0;
            end
         end

         if (issue[0])      rr_q <= 1'b1;
         else if (issue[1]) rr_q <= 1'b0;

         stall_q <= |starve;
      end
   end

   assign proc_stall = stall_q;
   assign ext0_ack   = (state_q[0] == PORT_DONE);
   assign ext1_ack   = (state_q[1] == PORT_DONE);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
//   Directed bench for regfile_write_arbiter with hand-computed expectations.
//   Inputs are driven on the falling edge; outputs are sampled 1 time unit
//   later, well away from the rising edge. A small regfile model records
//   what actually gets written.
module tb_regfile_write_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   logic          clock = 1'b0;
   logic          reset;
   logic          proc_we;
   logic [AW-1:0] proc_wreg;
   logic [DW-1:0] proc_wdata;
   logic          proc_stall;
   logic          ext0_req, ext1_req;
   logic [AW-1:0] ext0_reg, ext1_reg;
   logic [DW-1:0] ext0_data, ext1_data;
   logic          ext0_ack, ext1_ack;
   logic          rf_we;
   logic [AW-1:0] rf_wreg;
   logic [DW-1:0] rf_wdata;

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [DW-1:0] rf_mem [0:31];

   regfile_write_arbiter #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .MAX_WAIT   (8)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .proc_we    (proc_we),
      .proc_wreg  (proc_wreg),
      .proc_wdata (proc_wdata),
      .proc_stall (proc_stall),
      .ext0_req   (ext0_req),
      .ext0_reg   (ext0_reg),
      .ext0_data  (ext0_data),
      .ext0_ack   (ext0_ack),
      .ext1_req   (ext1_req),
      .ext1_reg   (ext1_reg),
      .ext1_data  (ext1_data),
      .ext1_ack   (ext1_ack),
      .rf_we      (rf_we),
      .rf_wreg    (rf_wreg),
      .rf_wdata   (rf_wdata)
   );

   always #5 clock = ~clock;

   // Regfile model: register 0 reads as zero regardless of writes.
   initial for (int i = 0; i < 32; i++) rf_mem[i] = '0;
   always @(posedge clock) if (rf_we && rf_wreg != '0) rf_mem[rf_wreg] <= rf_wdata;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic ncyc();
      @(negedge clock);
   endtask

   task automatic check_rf(input string tag, input logic we, input logic [AW-1:0] wreg,
                           input logic [DW-1:0] wdata);
      check({tag, "_we"}, 64'(rf_we), 64'(we));
      if (we) begin
         check({tag, "_reg"},  64'(rf_wreg),  64'(wreg));
         check({tag, "_data"}, 64'(rf_wdata), 64'(wdata));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      proc_we = 1'b1; proc_wreg = 5'd4; proc_wdata = 32'd1;
      ext0_req = 1'b0; ext0_reg = '0; ext0_data = '0;
      ext1_req = 1'b0; ext1_reg = '0; ext1_data = '0;

      // 1: reset gates the pass-through, then zero-latency processor write
      repeat (2) ncyc();
      #1;
      check("rst_rf_we", 64'(rf_we), 64'd0);
      check("rst_stall", 64'(proc_stall), 64'd0);
      check("rst_ack0", 64'(ext0_ack), 64'd0);
      check("rst_ack1", 64'(ext1_ack), 64'd0);
      ncyc(); reset = 1'b1; #1;
      check_rf("t1_proc", 1'b1, 5'd4, 32'd1);
      check("t1_ack0", 64'(ext0_ack), 64'd0);
      check("t1_ack1", 64'(ext1_ack), 64'd0);

      // 2: uncontended ext0 write r14 = 42
      ncyc(); proc_we = 1'b0;
      ext0_req = 1'b1; ext0_reg = 5'd14; ext0_data = 32'd42; #1;
      check_rf("t2_pre", 1'b0, '0, '0);
      ncyc(); #1;
      check_rf("t2_issue", 1'b1, 5'd14, 32'd42);
      check("t2_ack_issue", 64'(ext0_ack), 64'd0);
      ncyc(); #1;
      check("t2_ack_rise", 64'(ext0_ack), 64'd1);
      check_rf("t2_after", 1'b0, '0, '0);
      check("t2_mem14", 64'(rf_mem[14]), 64'd42);
      ncyc(); #1;
      check("t2_ack_hold", 64'(ext0_ack), 64'd1);
      ext0_req = 1'b0;
      ncyc(); #1;
      check("t2_ack_fall", 64'(ext0_ack), 64'd0);

      // uncontended ext1 write r3 = 33 (also returns rr to 0)
      ncyc(); ext1_req = 1'b1; ext1_reg = 5'd3; ext1_data = 32'd33;
      ncyc(); #1;
      check_rf("t2b_issue", 1'b1, 5'd3, 32'd33);
      ncyc(); #1;
      check("t2b_ack", 64'(ext1_ack), 64'd1);
      ext1_req = 1'b0;
      ncyc();

      // 3: simultaneous capture, rr=0 -> ext0 first
      ncyc();
      ext0_req = 1'b1; ext0_reg = 5'd15; ext0_data = 32'd7;
      ext1_req = 1'b1; ext1_reg = 5'd16; ext1_data = 32'd9;
      ncyc(); #1;
      check_rf("t3_first", 1'b1, 5'd15, 32'd7);
      ncyc(); #1;
      check_rf("t3_second", 1'b1, 5'd16, 32'd9);
      check("t3_ack0_a", 64'(ext0_ack), 64'd1);
      check("t3_ack1_a", 64'(ext1_ack), 64'd0);
      ncyc(); #1;
      check("t3_ack0_b", 64'(ext0_ack), 64'd1);
      check("t3_ack1_b", 64'(ext1_ack), 64'd1);
      check_rf("t3_idle", 1'b0, '0, '0);
      ext0_req = 1'b0; ext1_req = 1'b0;
      ncyc(); #1;
      check("t3_ack0_c", 64'(ext0_ack), 64'd0);
      check("t3_ack1_c", 64'(ext1_ack), 64'd0);
      // rr ended at 0: a second simultaneous pair again starts with ext0
      ext0_req = 1'b1; ext0_reg = 5'd18; ext0_data = 32'd1;
      ext1_req = 1'b1; ext1_reg = 5'd19; ext1_data = 32'd2;
      ncyc(); #1;
      check_rf("t3_rr_first", 1'b1, 5'd18, 32'd1);
      ncyc(); #1;
      check_rf("t3_rr_second", 1'b1, 5'd19, 32'd2);
      ncyc(); ext0_req = 1'b0; ext1_req = 1'b0;
      ncyc();

      // 4: starvation with MAX_WAIT=8
      ncyc();
      proc_we = 1'b1; proc_wreg = 5'd5; proc_wdata = 32'd100;
      ext1_req = 1'b1; ext1_reg = 5'd17; ext1_data = 32'd82; #1;
      check_rf("t4_c0", 1'b1, 5'd5, 32'd100);
      for (int i = 1; i <= 9; i++) begin
         ncyc(); proc_wdata = 32'(100 + i); #1;
         check("t4_nostall", 64'(proc_stall), 64'd0);
         check_rf("t4_proc", 1'b1, 5'd5, 32'(100 + i));
      end
      ncyc(); #1;
      check("t4_stall", 64'(proc_stall), 64'd1);
      check_rf("t4_ext", 1'b1, 5'd17, 32'd82);
      ncyc(); #1;
      check("t4_unstall", 64'(proc_stall), 64'd0);
      check("t4_ack1", 64'(ext1_ack), 64'd1);
      check_rf("t4_resume", 1'b1, 5'd5, 32'd109);
      check("t4_mem17", 64'(rf_mem[17]), 64'd82);
      ext1_req = 1'b0; proc_we = 1'b0;
      ncyc();

      // 5: external write to r0 is consumed and acked but never enabled
      ncyc(); ext0_req = 1'b1; ext0_reg = 5'd0; ext0_data = 32'd5;
      ncyc(); #1;
      check_rf("t5_r0", 1'b0, '0, '0);
      ncyc(); #1;
      check("t5_ack0", 64'(ext0_ack), 64'd1);
      check("t5_mem0", 64'(rf_mem[0]), 64'd0);
      ext0_req = 1'b0;
      ncyc();

      // 6: asynchronous reset with ext0 HELD and ext1 DONE
      ncyc(); ext1_req = 1'b1; ext1_reg = 5'd20; ext1_data = 32'd1;
      ncyc(); ext0_req = 1'b1; ext0_reg = 5'd21; ext0_data = 32'd77;
      ncyc(); proc_we = 1'b1; proc_wreg = 5'd6; proc_wdata = 32'd3; #1;
      check("t6_ack1_pre", 64'(ext1_ack), 64'd1);
      check_rf("t6_proc", 1'b1, 5'd6, 32'd3);
      #1 reset = 1'b0; #1;
      check("t6_ack0", 64'(ext0_ack), 64'd0);
      check("t6_ack1", 64'(ext1_ack), 64'd0);
      check("t6_stall", 64'(proc_stall), 64'd0);
      check("t6_rf_we", 64'(rf_we), 64'd0);
      ext0_req = 1'b0; ext1_req = 1'b0; proc_we = 1'b0;
      ncyc(); reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ncyc(); #1;
         check("t6_no_issue", 64'(rf_we), 64'd0);
      end
      check("t6_mem21", 64'(rf_mem[21]), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register-file write port between the processor writeback stage and two external requesters, such as board-IO and motor-status logic that post values into the registers software polls.
- Processor writeback has priority by default. External writes are captured into per-port holding registers and drained in round-robin order.
- A starvation counter stalls the processor when an external write has waited too long.
- Sits between the processor writeback and the regfile write inputs (ctrl_writeEnable, ctrl_writeReg, data_writeReg).

Parameters:
- DATA_WIDTH, 32, register data width.
- ADDR_WIDTH, 5, register index width.
- MAX_WAIT, 8, cycles a held external write may be bypassed before the processor is stalled (1..255).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- proc_we  in  1  processor writeback enable.
- proc_wreg  in  ADDR_WIDTH  processor destination register.
- proc_wdata  in  DATA_WIDTH  processor writeback data.
- proc_stall  out  1  registered; processor must freeze writeback and hold proc_* while high.
- ext0_req  in  1  port 0 write request (4-phase).
- ext0_reg  in  ADDR_WIDTH  port 0 destination register.
- ext0_data  in  DATA_WIDTH  port 0 data.
- ext0_ack  out  1  port 0 write completed.
- ext1_req, ext1_reg, ext1_data, ext1_ack  same as port 0, for port 1.
- rf_we  out  1  regfile write enable.
- rf_wreg  out  ADDR_WIDTH  regfile write index.
- rf_wdata  out  DATA_WIDTH  regfile write data.

Behaviour:
- Reset (reset=0, asynchronous):
  - Both ports go to IDLE; holding registers are invalidated.
  - Wait counters clear to 0; round-robin pointer rr=0.
  - proc_stall=0, ext0_ack=0, ext1_ack=0.
  - rf_we is forced to 0 while reset=0, including any pass-through from proc_we.
  - Reset mid-operation drops held writes without acking them.
- Per-port FSM (IDLE, HELD, DONE):
  - IDLE and req=1: capture reg/data into the holding register on the edge, go to HELD.
  - HELD: on the edge where this port is issued to the regfile, go to DONE.
  - DONE: ack=1 (registered). Stay until req=0, then go to IDLE.
  - ack is 0 in IDLE and HELD.
  - The requester must keep reg/data stable from req rise through the capture edge, and must keep req high until ack.
- Issue selection (combinational, one write per cycle):
  - proc_we=1 and proc_stall=0: processor drives rf_* in the same cycle (zero latency). No port is issued.
  - Otherwise, if any port is HELD: issue it. If both are HELD, issue port rr. After issuing port k, rr becomes 1-k.
  - Otherwise: rf_we=0.
  - While proc_stall=1, proc_we is ignored and the processor must re-present its write after the stall ends.
- Register 0:
  - Any write to index 0 yields rf_we=0.
  - An external write to index 0 is still treated as issued and still acks.
- Starvation:
  - Each HELD port's wait counter increments on every cycle it is not issued. It clears on issue.
  - When a counter equals MAX_WAIT, proc_stall is set on the next edge.
  - proc_stall clears on the edge after every port whose counter reached MAX_WAIT has been issued.
- Ordering:
  - Processor and external writes to the same register in the same cycle: the processor writes first; the external write lands later and wins.
  - ext0 and ext1 to the same register: written in rr order; the later write wins.
- Latency:
  - Processor: 0 cycles.
  - External, uncontended: req rise → capture edge → issue in the next cycle → ack high one edge after issue. Minimum 2 edges from req rise to ack.

Test Plan:
1. Reset release, proc_we=1, proc_wreg=4, proc_wdata=1 → rf_we=1, rf_wreg=4, rf_wdata=1 in the same cycle; both acks 0.
2. ext0 writes 42 to r14 while proc_we=0 → rf_we=1, rf_wreg=14, rf_wdata=42 one cycle after capture. ext0_ack rises next edge and holds until ext0_req drops, then falls next edge.
3. ext0 (r15, 7) and ext1 (r16, 9) captured on the same edge, rr=0 → r15 issued first, r16 the next cycle. Acks in the same order; rr ends at 0.
4. proc_we=1 continuously, ext1 HELD (r17, 82), MAX_WAIT=8 → counter hits 8, proc_stall=1 next edge. r17 written during the stall; proc_stall=0 the following edge; processor writes resume.
5. ext0 writes r0=5 → rf_we stays 0; ext0_ack still asserts; regfile r0 reads 0.
6. reset asserted while ext0 HELD and ext1 DONE → immediately both acks=0, proc_stall=0, rf_we=0. After release, the held write is never issued.
